// File: rtl/queue_sched_pkg.sv
// Shared definitions for the queue round-robin scheduler and ring arbiters.
package queue_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int unsigned CNT_W = 7;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr, wrapping modulo NQ.
module rr_pick #(
  parameter int unsigned NQ = 4,
  parameter int unsigned PW = 2
) (
  input  logic [NQ-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] pick,
  output logic          any
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    pick    = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // Offset 1..NQ so the last winner is considered last.
    for (int unsigned k = 1; k <= NQ; k++) begin
      w_idx = PW'((32'(ptr) + k) % NQ);
      if (!w_found && req[w_idx]) begin
        pick    = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/queue_rr_sched.sv
// Round-robin read scheduler: grants one FWFT queue at a time and pops its
// words into a single registered valid/ready output stage.
module queue_rr_sched
  import queue_sched_pkg::*;
#(
  parameter int unsigned NQ       = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BURST    = 8,
  parameter int unsigned PKT_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NQ-1:0]          q_empty,
  input  logic [NQ*WIDTH-1:0]    q_dout,
  output logic [NQ-1:0]          q_rd_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [clog2(NQ)-1:0]   out_src,
  output logic                   busy
);

  localparam int unsigned PW = clog2(NQ);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_g;
  logic [PW-1:0]     r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [PW-1:0]     r_out_src;

  logic [NQ-1:0]     w_req;
  logic [PW-1:0]     w_pick;
  logic              w_any;
  logic [WIDTH-1:0]  w_words [NQ];
  logic [WIDTH-1:0]  w_head;
  logic              w_gempty;
  logic              w_pop;
  logic              w_last;
  logic              w_burst_end;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_words
    assign w_words[gi] = q_dout[gi*WIDTH +: WIDTH];
  end

  assign w_req = ~q_empty;

  rr_pick #(
    .NQ (NQ),
    .PW (PW)
  ) u_pick (
    .req  (w_req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_head      = w_words[r_g];
  assign w_gempty    = q_empty[r_g];
  assign w_last      = w_head[WIDTH-1];
  assign w_burst_end = (r_cnt == CNT_W'(BURST - 1));
  // A full output register with no accept blocks the pop, so nothing is lost.
  assign w_pop       = ~rst & (r_state == XFER) & ~w_gempty & (~r_out_valid | out_ready);

  always_comb begin
    q_rd_en = '0;
    if (w_pop) q_rd_en[r_g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = XFER;
      XFER: begin
        if (PKT_MODE != 0) begin
          if (w_pop && w_last) w_state_nxt = IDLE;
        end else begin
          if (w_pop && w_burst_end)    w_state_nxt = IDLE;
          else if (!w_pop && w_gempty) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= PW'(NQ - 1);
      r_g         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (w_any) begin
          r_g   <= w_pick;
          r_ptr <= w_pick;
        end
        r_cnt <= '0;
      end else if (w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_pop) begin
        r_out_data  <= w_head;
        r_out_src   <= r_g;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = (r_state == XFER);

endmodule

// File: tb/tb_queue_rr_sched.sv
// Directed bench: burst-mode and packet-mode schedulers share one FWFT queue model.
`timescale 1ns/1ps
module tb_queue_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, mode, out_ready, tb_clr;
  logic [3:0]   qe, q_empty0, q_empty1, rd0, rd1, rd;
  logic [127:0] q_dout;
  logic         ov0, ov1, ov, b0, b1, busy;
  logic [31:0]  od0, od1, od;
  logic [1:0]   os0, os1, os;

  logic [7:0]   hd [4];
  logic [7:0]   tl [4];
  logic [31:0]  mem [4][256];

  int           n = 0, bad = 0, cyc = 0, total = 0, pass = 0;
  int           rdcnt [4];
  logic [31:0]  log_d [512];
  logic [1:0]   log_s [512];
  int           log_c [512];

  assign q_empty0 = mode ? 4'hF : qe;
  assign q_empty1 = mode ? qe : 4'hF;
  assign rd   = mode ? rd1 : rd0;
  assign ov   = mode ? ov1 : ov0;
  assign od   = mode ? od1 : od0;
  assign os   = mode ? os1 : os0;
  assign busy = mode ? b1 : b0;

  queue_rr_sched #(.NQ(4), .WIDTH(32), .BURST(8), .PKT_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .q_empty(q_empty0), .q_dout(q_dout), .q_rd_en(rd0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_src(os0), .busy(b0));

  queue_rr_sched #(.NQ(4), .WIDTH(32), .BURST(8), .PKT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .q_empty(q_empty1), .q_dout(q_dout), .q_rd_en(rd1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_src(os1), .busy(b1));

  for (genvar gi = 0; gi < 4; gi++) begin : g_q
    assign qe[gi] = (hd[gi] == tl[gi]);
    assign q_dout[gi*32 +: 32] = mem[gi][hd[gi]];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (tb_clr)     hd[i] <= 8'd0;
      else if (rd[i]) hd[i] <= hd[i] + 8'd1;
    end
  end

  // Accepts are logged half a cycle ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst && ov && out_ready) begin
      log_d[n] <= od;
      log_s[n] <= os;
      log_c[n] <= cyc;
      n        <= n + 1;
    end
    for (int i = 0; i < 4; i++) rdcnt[i] <= rdcnt[i] + int'(rd[i]);
    if (((rd & (rd - 4'd1)) != 4'd0) || ((rd & qe) != 4'd0)) bad <= bad + 1;
  end

  function automatic logic [31:0] mk(input int q, input int s, input bit last);
    return {last, 15'd0, 8'(q), 8'(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int q, input logic [31:0] d);
    mem[q][tl[q]] = d;
    tl[q] = tl[q] + 8'd1;
  endtask

  task automatic wait_n(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && n < target; k++) tick();
    chk(tag, n, target);
  endtask

  int base, r0, r1, exp_q, exp_s;

  initial begin
    rst = 1'b1; tb_clr = 1'b1; mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tl[i] = 8'd0;
    repeat (3) tick();
    chk("rst_valid0", ov0, 0);
    chk("rst_valid1", ov1, 0);
    chk("rst_busy",   b0 | b1, 0);
    chk("rst_rden",   {rd1, rd0}, 0);
    chk("rst_data",   od0, 0);
    chk("rst_src",    os0, 0);
    rst = 1'b0; tb_clr = 1'b0;
    tick();

    // Single source, three words
    base = n; r0 = rdcnt[0];
    push(0, mk(0, 0, 0)); push(0, mk(0, 1, 0)); push(0, mk(0, 2, 0));
    wait_n(base + 3, 50, "t1_count");
    for (int i = 0; i < 3; i++) begin
      chk("t1_data", log_d[base+i], mk(0, i, 0));
      chk("t1_src",  log_s[base+i], 0);
      if (i > 0) chk("t1_gap", log_c[base+i] - log_c[base+i-1], 1);
    end
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_pops", rdcnt[0] - r0, 3);

    // Fairness: last grant was queue 0, so queue 1 leads
    base = n;
    for (int q = 0; q < 4; q++)
      for (int s = 0; s < 20; s++) push(q, mk(q, s, 0));
    wait_n(base + 80, 400, "t2_count");
    for (int i = 0; i < 80; i++) begin
      if (i < 64) begin
        exp_q = (1 + i / 8) % 4;
        exp_s = (i / 32) * 8 + i % 8;
      end else begin
        exp_q = (1 + (i - 64) / 4) % 4;
        exp_s = 16 + (i - 64) % 4;
      end
      chk("t2_data", log_d[base+i], mk(exp_q, exp_s, 0));
      chk("t2_src",  log_s[base+i], 32'(exp_q));
      if (i > 0 && i < 64) chk("t2_gap", log_c[base+i] - log_c[base+i-1], (i % 8 == 0) ? 2 : 1);
    end
    chk("t2_rden_ok", bad, 0);

    // Backpressure for 5 cycles mid-burst on queue 1
    base = n;
    for (int s = 0; s < 16; s++) push(1, mk(1, s, 0));
    wait_n(base + 3, 50, "t3_pre");
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_hold_data",  od, mk(1, 3, 0));
      chk("t3_hold_src",   os, 1);
      chk("t3_hold_valid", ov, 1);
      chk("t3_hold_rden",  rd, 0);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    wait_n(base + 16, 100, "t3_count");
    for (int i = 0; i < 16; i++) begin
      chk("t3_seq", log_d[base+i], mk(1, i, 0));
      chk("t3_src", log_s[base+i], 1);
    end

    // Packet mode: queue 1 stalls mid-packet while queue 2 waits
    mode = 1'b1;
    base = n; r1 = rdcnt[1];
    push(1, mk(1, 0, 0)); push(1, mk(1, 1, 0));
    push(2, mk(2, 0, 0)); push(2, mk(2, 1, 0)); push(2, mk(2, 2, 1));
    for (int k = 0; k < 50 && (rdcnt[1] - r1) < 2; k++) tick();
    chk("t5_first2", rdcnt[1] - r1, 2);
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold_busy", busy, 1);
      chk("t5_hold_rden", rd, 0);
      tick();
    end
    push(1, mk(1, 2, 0)); push(1, mk(1, 3, 1));
    wait_n(base + 7, 100, "t5_count");
    for (int i = 0; i < 4; i++) begin
      chk("t5_pkt1", log_d[base+i], mk(1, i, i == 3));
      chk("t5_src1", log_s[base+i], 1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("t5_pkt2", log_d[base+4+i], mk(2, i, i == 2));
      chk("t5_src2", log_s[base+4+i], 2);
    end
    tick(); tick();
    chk("t5_idle", busy, 0);

    // Reset during a queue 2 burst
    mode = 1'b0;
    base = n;
    for (int s = 0; s < 10; s++) push(2, mk(2, s, 0));
    wait_n(base + 2, 50, "t6_pre");
    push(0, mk(0, 0, 0)); push(0, mk(0, 1, 0)); push(0, mk(0, 2, 0));
    push(3, mk(3, 0, 0)); push(3, mk(3, 1, 0)); push(3, mk(3, 2, 0));
    rst = 1'b1;
    #1;
    chk("t6_rden_in_rst", rd, 0);
    tick();
    chk("t6_valid", ov, 0);
    chk("t6_busy",  busy, 0);
    chk("t6_rden",  rd, 0);
    rst = 1'b0;
    base = n;
    wait_n(base + 1, 50, "t6_count");
    chk("t6_first_src",  log_s[base], 0);
    chk("t6_first_data", log_d[base], mk(0, 0, 0));
    chk("t6_rden_ok", bad, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
